ccr_stack_unit: RTL
===================

CCR_STACK_UNIT -- requirements
Module: ccr_stack_unit

Interface
REQ-001 Parameter NFLAGS, default 4, flag count; bit0=Z, bit1=N, bit2=C, bit3=V; bits 4+ are user flags; legal range 4..16.
REQ-002 Parameter DEPTH, default 2, save-stack depth in entries; legal range 1..8.
REQ-003 Parameter OPW, default 4, opcode width; legal range 4..8; only the low 4 bits are decoded, upper bits SHALL be zero for decoded ops.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 valid_i  in  1  instruction at writeback this cycle.
REQ-007 op_code  in  OPW  writeback opcode.
REQ-008 ra  in  2  writeback ra field (sub-op select).
REQ-009 alu_flags_i  in  NFLAGS  flag results from the ALU.
REQ-010 save_i  in  1  push flags (interrupt entry).
REQ-011 restore_i  in  1  pop flags (RTI).
REQ-012 flags_o  out  NFLAGS  registered CCR.
REQ-013 flag_en_o  out  NFLAGS  combinational enable mask for the current op (0 when valid_i=0).
REQ-014 stack_cnt_o  out  clog2(DEPTH+1)  occupied entries.
REQ-015 stack_full_o / stack_empty_o  out  1 each  cnt==DEPTH / cnt==0.
REQ-016 err_o  out  1  registered one-cycle pulse on overflow/underflow.

Function
REQ-017 Enable decode: 0010/0011 -> Z,N,C,V; 0100/0101 -> Z,N; 0110 -> C; 1000 with ra 00/01 -> Z,N; 1000 with ra 10/11 -> Z,N,C,V; all other ops -> none; bits 4+ never enabled.
REQ-018 Update: on a clock edge with valid_i=1 and no save/restore, each flags_o bit with enable=1 takes alu_flags_i; other bits hold; latency 1 cycle.
REQ-019 Op 0110: ra 00/01 (RLC/RRC) C takes alu_flags_i[2]; ra 10 (SETC) C=1; ra 11 (CLRC) C=0, regardless of alu_flags_i.
REQ-020 Save (save_i=1, restore_i=0, not full): push the updated value (REQ-018 applied first if valid_i=1) to top; cnt+1; flags_o takes the updated value.
REQ-021 Restore (restore_i=1, save_i=0, not empty): flags_o takes top entry; cnt-1; a same-cycle valid_i update is discarded.
REQ-022 save_i and restore_i together, not empty: swap -- flags_o takes top entry, top entry takes current flags_o; cnt unchanged; valid_i update discarded.
REQ-023 Save when full: no push, cnt unchanged, flag update per REQ-018 still applies, err_o=1 next cycle.
REQ-024 Restore or swap when empty: flags_o and cnt unchanged, valid_i update discarded, err_o=1 next cycle.
REQ-025 err_o SHALL be 0 in any cycle not directly following an error event.
REQ-026 Stack is LIFO; entries above cnt are don't-care and never observable.

Reset
REQ-027 rst=1 at a clock edge: flags_o=0, stack_cnt_o=0, err_o=0; reset dominates all other inputs including save_i/restore_i.
REQ-028 Stack storage SHALL need no reset; reset mid-sequence discards all saved entries.

Structure
REQ-029 Package ccr_pkg holds opcode constants (ADD, SUB, AND, OR, SHC, UNARY), flag index constants (Z=0, N=1, C=2, V=3) and ra sub-op constants.
REQ-030 Sub-module ccr_flag_decode: combinational op_code/ra -> enable mask and C-forcing controls; all state resides in ccr_stack_unit.

Verification
REQ-031 Reset, then ADD valid_i=1, alu_flags_i=4'b1011 -> next cycle flags_o=4'b1011, flag_en_o=4'b1111 during the op.
REQ-032 flags_o=4'b1111, AND with alu_flags_i=4'b0000 -> flags_o=4'b1100; then CLRC with alu_flags_i[2]=1 -> flags_o=4'b1000.
REQ-033 DEPTH=2: save flags 4'b0001, update to 4'b0010, save, update to 4'b0100, restore -> 4'b0010, restore -> 4'b0001, stack_empty_o=1.
REQ-034 DEPTH=2, full: save_i -> err_o high exactly one cycle, cnt stays 2; empty: restore_i -> err_o pulse, flags_o unchanged.
REQ-035 cnt=1 (top 4'b0101), flags_o=4'b1010, save_i=restore_i=1 with ADD valid -> flags_o=4'b0101, top=4'b1010, cnt=1.
REQ-036 cnt=2 with rst=1 and restore_i=1 same edge -> flags_o=0, cnt=0, err_o=0.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared constants for the condition-code register and its save stack.
package ccr_pkg;

    // Writeback opcodes. Only the low nibble is decoded.
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_SHC   = 4'b0110;
    localparam logic [3:0] OP_UNARY = 4'b1000;

    // Flag bit positions within the CCR.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    // ra sub-op selects for the shift/carry group.
    localparam logic [1:0] RA_RLC  = 2'b00;
    localparam logic [1:0] RA_RRC  = 2'b01;
    localparam logic [1:0] RA_SETC = 2'b10;
    localparam logic [1:0] RA_CLRC = 2'b11;

endpackage

// File: rtl/ccr_flag_decode.sv
// Combinational decode of opcode/ra into a flag write-enable mask plus the
// controls that force the carry flag for SETC/CLRC.
module ccr_flag_decode
    import ccr_pkg::*;
#(
    parameter int NFLAGS = 4,
    parameter int OPW    = 4
) (
    input  logic [OPW-1:0]    i_opCode,
    input  logic [1:0]        i_ra,
    output logic [NFLAGS-1:0] o_flagEn,
    output logic              o_forceC,
    output logic              o_forceCVal
);

    logic w_upperZero;
    logic [3:0] w_mask4;

    assign w_upperZero = ((i_opCode >> 4) == '0);

    // Map the low opcode nibble to Z/N/C/V enables; user flags never enabled.
    always_comb begin
        w_mask4     = 4'b0000;
        o_forceC    = 1'b0;
        o_forceCVal = 1'b0;
        if (w_upperZero) begin
            unique case (i_opCode[3:0])
                OP_ADD, OP_SUB: w_mask4 = 4'b1111;
                OP_AND, OP_OR:  w_mask4 = 4'b0011;
                OP_SHC: begin
                    w_mask4 = 4'b0100;
                    if (i_ra == RA_SETC) begin
                        o_forceC    = 1'b1;
                        o_forceCVal = 1'b1;
                    end else if (i_ra == RA_CLRC) begin
                        o_forceC    = 1'b1;
                        o_forceCVal = 1'b0;
                    end
                end
                OP_UNARY: w_mask4 = i_ra[1] ? 4'b1111 : 4'b0011;
                default:  w_mask4 = 4'b0000;
            endcase
        end
        o_flagEn      = '0;
        o_flagEn[3:0] = w_mask4;
    end

endmodule

// File: rtl/ccr_stack_unit.sv
// Condition-code register with a small LIFO save stack used for interrupt
// entry (save) and return (restore), including swap and error reporting.
module ccr_stack_unit
    import ccr_pkg::*;
#(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 2,
    parameter int OPW    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    input  logic [OPW-1:0]               op_code,
    input  logic [1:0]                   ra,
    input  logic [NFLAGS-1:0]            alu_flags_i,
    input  logic                         save_i,
    input  logic                         restore_i,
    output logic [NFLAGS-1:0]            flags_o,
    output logic [NFLAGS-1:0]            flag_en_o,
    output logic [$clog2(DEPTH+1)-1:0]   stack_cnt_o,
    output logic                         stack_full_o,
    output logic                         stack_empty_o,
    output logic                         err_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] r_flags;
    logic [NFLAGS-1:0] r_stack [0:(1<<AW)-1];
    logic [CW-1:0]     r_cnt;
    logic              r_err;

    logic [NFLAGS-1:0] w_decEn;
    logic              w_forceC;
    logic              w_forceCVal;
    logic [NFLAGS-1:0] w_upd;
    logic              w_full;
    logic              w_empty;
    logic [AW-1:0]     w_topIdx;
    logic [AW-1:0]     w_pushIdx;
    logic              w_doPush;
    logic              w_doPop;
    logic              w_doSwap;
    logic              w_err;

    ccr_flag_decode #(
        .NFLAGS (NFLAGS),
        .OPW    (OPW)
    ) u_decode (
        .i_opCode    (op_code),
        .i_ra        (ra),
        .o_flagEn    (w_decEn),
        .o_forceC    (w_forceC),
        .o_forceCVal (w_forceCVal)
    );

    assign w_full    = (r_cnt == CW'(DEPTH));
    assign w_empty   = (r_cnt == '0);
    assign w_topIdx  = AW'(r_cnt - CW'(1));
    assign w_pushIdx = AW'(r_cnt);

    // A lone save pushes, a lone restore pops, both together swap with the top.
    assign w_doPush = save_i & ~restore_i & ~w_full;
    assign w_doPop  = restore_i & ~save_i & ~w_empty;
    assign w_doSwap = save_i & restore_i & ~w_empty;
    assign w_err    = (save_i & ~restore_i & w_full) | (restore_i & w_empty);

    // Candidate next CCR: enabled bits take the ALU result, SETC/CLRC force C.
    always_comb begin
        w_upd = r_flags;
        if (valid_i) begin
            for (int i = 0; i < NFLAGS; i++) begin
                if (w_decEn[i]) begin
                    w_upd[i] = alu_flags_i[i];
                end
            end
            if (w_forceC) begin
                w_upd[FLAG_C] = w_forceCVal;
            end
        end
    end

    // CCR, occupancy and error pulse; any restore request discards the update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_doPop || w_doSwap) begin
                r_flags <= r_stack[w_topIdx];
            end else if (!restore_i) begin
                r_flags <= w_upd;
            end
            if (w_doPush) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_doPop) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Stack storage is never reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_doPush) begin
                r_stack[w_pushIdx] <= w_upd;
            end else if (w_doSwap) begin
                r_stack[w_topIdx] <= r_flags;
            end
        end
    end

    assign flags_o       = r_flags;
    assign flag_en_o     = valid_i ? w_decEn : '0;
    assign stack_cnt_o   = r_cnt;
    assign stack_full_o  = w_full;
    assign stack_empty_o = w_empty;
    assign err_o         = r_err;

endmodule
